// File: rtl/fetch_pkg.sv
// fetch_pkg: shared constants, FSM state type and FIFO entry type for the fetch unit
package fetch_pkg;
    localparam int INSTR_BYTES = 4;
    localparam int FETCH_DEPTH = 2;
    typedef enum logic [0:0] {
        ST_FETCH   = 1'b0,
        ST_DISCARD = 1'b1
    } fetch_state_e;
    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: 2-entry {instr, pc} FIFO whose head is always a register
// Ports: clk, rst_n (async active-low); push/din write, pop advances head,
//        flush empties; head is the oldest entry; full/empty status.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter type entry_t = fetch_entry_t
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   push,
    input  logic   pop,
    input  logic   flush,
    input  entry_t din,
    output entry_t head,
    output logic   full,
    output logic   empty
);
    entry_t     tail;
    logic [1:0] cnt;
    logic [1:0] wr;
    // slot a push lands in once this cycle's pop has shifted the queue
    assign wr    = cnt - {1'b0, pop};
    assign full  = cnt == 2'(FETCH_DEPTH);
    assign empty = cnt == 2'd0;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            head <= '0;
            tail <= '0;
        end else if (flush) begin
            cnt <= '0;
        end else begin
            if (pop) head <= tail;
            if (push && wr == 2'd0) head <= din;
            if (push && wr == 2'd1) tail <= din;
            cnt <= cnt + {1'b0, push} - {1'b0, pop};
        end
    end
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch with credit-limited requests, 2-entry buffer and redirect discard
// Ports: clk, rst_n (async active-low); imem_req_* request channel (valid/ready/addr);
//        imem_rsp_* in-order response channel (never back-pressured);
//        instr/instr_pc/instr_valid/instr_ready decode channel; redirect/redirect_pc.
// Optional: FETCH_PERF_CNT_EN adds perf_fetched and perf_stall counters.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = 32'h0000_0000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic                  imem_req_valid,
    output logic [ADDR_WIDTH-1:0] imem_req_addr,
    input  logic                  imem_req_ready,
    input  logic                  imem_rsp_valid,
    input  logic [DATA_WIDTH-1:0] imem_rsp_data,
    output logic                  instr_valid,
    output logic [DATA_WIDTH-1:0] instr,
    output logic [ADDR_WIDTH-1:0] instr_pc,
    input  logic                  instr_ready,
    input  logic                  redirect,
    input  logic [ADDR_WIDTH-1:0] redirect_pc
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]           perf_fetched,
    output logic [31:0]           perf_stall
`endif
);
    typedef struct packed {
        logic [DATA_WIDTH-1:0] instr;
        logic [ADDR_WIDTH-1:0] pc;
    } entry_t;
    fetch_state_e          state;
    logic [ADDR_WIDTH-1:0] pc;
    logic [ADDR_WIDTH-1:0] rsp_pc;
    logic [ADDR_WIDTH-1:0] tgt;
    logic [1:0]            outst;
    logic [1:0]            outst_nx;
    logic [1:0]            drop;
    logic [1:0]            drop_nx;
    logic [1:0]            occ;
    logic                  acc;
    logic                  push;
    logic                  pop;
    logic                  full;
    logic                  empty;
    entry_t                head;
    assign tgt            = redirect_pc & ~ADDR_WIDTH'(INSTR_BYTES - 1);
    assign occ            = {full, !full && !empty};
    // every outstanding request already owns a buffer slot, so responses never stall
    assign imem_req_valid = rst_n && !redirect && ({1'b0, outst} + {1'b0, occ} < 3'd2);
    assign imem_req_addr  = pc;
    assign acc            = imem_req_valid && imem_req_ready;
    assign pop            = instr_valid && instr_ready;
    assign push           = imem_rsp_valid && !redirect && state == ST_FETCH;
    assign outst_nx       = outst + {1'b0, acc} - {1'b0, imem_rsp_valid};
    // on redirect everything still in flight is stale
    assign drop_nx        = redirect ? outst_nx : drop - {1'b0, imem_rsp_valid && drop != 2'd0};
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc     <= RESET_PC;
            rsp_pc <= RESET_PC;
            outst  <= '0;
            drop   <= '0;
            state  <= ST_FETCH;
        end else begin
            pc     <= redirect ? tgt : acc ? pc + ADDR_WIDTH'(INSTR_BYTES) : pc;
            rsp_pc <= redirect ? tgt : push ? rsp_pc + ADDR_WIDTH'(INSTR_BYTES) : rsp_pc;
            outst  <= outst_nx;
            drop   <= drop_nx;
            state  <= drop_nx != 2'd0 ? ST_DISCARD : ST_FETCH;
        end
    end
    fetch_fifo #(
        .entry_t(entry_t)
    ) u_fifo (
        .clk  (clk),
        .rst_n(rst_n),
        .push (push),
        .pop  (pop),
        .flush(redirect),
        .din  ('{instr: imem_rsp_data, pc: rsp_pc}),
        .head (head),
        .full (full),
        .empty(empty)
    );
    assign instr_valid = !empty;
    assign instr       = head.instr;
    assign instr_pc    = head.pc;
`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetched <= '0;
            perf_stall   <= '0;
        end else begin
            if (pop) perf_fetched <= perf_fetched + 32'd1;
            if (!instr_valid) perf_stall <= perf_stall + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: randomized bench for fetch_unit against an in-order instruction stream model
module tb_fetch_unit;
    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready = 1'b0;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;

    fetch_unit dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .imem_req_valid(imem_req_valid),
        .imem_req_addr (imem_req_addr),
        .imem_req_ready(imem_req_ready),
        .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data (imem_rsp_data),
        .instr_valid   (instr_valid),
        .instr         (instr),
        .instr_pc      (instr_pc),
        .instr_ready   (instr_ready),
        .redirect      (redirect),
        .redirect_pc   (redirect_pc)
    );

    always #5 clk = ~clk;

    int          n_vec = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          first_req_cyc = -1;
    int          first_iv_cyc = -1;
    int          live = 0;
    int          mem_mode = 1;
    logic [31:0] exp_pc = '0;
    logic [31:0] exp_req = '0;
    logic [31:0] hold_addr = '0;
    logic        hold_pend = 1'b0;
    logic [31:0] q[$];
    logic [31:0] acc_log[$];
    logic [31:0] hs_log[$];

    function automatic logic [31:0] mem(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step(input logic rr, input logic ir, input logic rd, input logic [31:0] rp);
        logic        acc;
        logic        hs;
        logic [31:0] a;
        @(negedge clk);
        imem_req_ready = rr;
        instr_ready    = ir;
        redirect       = rd;
        redirect_pc    = rp;
        imem_rsp_valid = 1'b0;
        if (q.size() > 0 && (mem_mode == 1 || (mem_mode == 0 && $urandom_range(1, 0) == 1))) begin
            a = q.pop_front();
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem(a);
        end
        #1;
        acc = imem_req_valid && rr;
        hs  = instr_valid && ir;
        if (rd) check("req_low_in_redirect", 32'(imem_req_valid), 0);
        if (hold_pend && !rd) begin
            check("req_valid_hold", 32'(imem_req_valid), 1);
            check("req_addr_hold", imem_req_addr, hold_addr);
        end
        if (imem_req_valid) check("req_addr_align", imem_req_addr & 32'h3, 0);
        if (instr_valid && first_iv_cyc < 0) first_iv_cyc = cyc;
        if (acc) begin
            check("req_addr", imem_req_addr, exp_req);
            q.push_back(imem_req_addr);
            acc_log.push_back(imem_req_addr);
            exp_req = exp_req + 32'd4;
            live++;
            if (first_req_cyc < 0) first_req_cyc = cyc;
        end
        if (hs) begin
            check("instr_pc", instr_pc, exp_pc);
            check("instr", instr, mem(exp_pc));
            hs_log.push_back(instr_pc);
            exp_pc = exp_pc + 32'd4;
            live--;
        end
        if (rd) begin
            exp_pc  = rp & 32'hFFFF_FFFC;
            exp_req = rp & 32'hFFFF_FFFC;
            live    = 0;
        end
        check("credit_limit", 32'(live <= 2), 1);
        hold_pend = imem_req_valid && !rr;
        hold_addr = imem_req_addr;
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        #2;
        rst_n          = 1'b0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        instr_ready    = 1'b0;
        redirect       = 1'b0;
        #1;
        check("rst_req_valid", 32'(imem_req_valid), 0);
        check("rst_instr_valid", 32'(instr_valid), 0);
        check("rst_instr", instr, 0);
        check("rst_instr_pc", instr_pc, 0);
        q.delete();
        exp_pc    = '0;
        exp_req   = '0;
        live      = 0;
        hold_pend = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n         = 1'b1;
        cyc           = 0;
        first_req_cyc = -1;
        first_iv_cyc  = -1;
    endtask

    task automatic boot_check();
        mem_mode = 1;
        acc_log.delete();
        hs_log.delete();
        repeat (8) step(1, 1, 0, 0);
        check("boot_first_req_cycle", first_req_cyc, 0);
        check("boot_valid_latency", first_iv_cyc - first_req_cyc, 2);
        check("boot_req_count", 32'(acc_log.size() >= 3), 1);
        check("boot_hs_count", 32'(hs_log.size() >= 1), 1);
        if (acc_log.size() >= 3) begin
            check("boot_addr0", acc_log[0], 32'h0);
            check("boot_addr1", acc_log[1], 32'h4);
            check("boot_addr2", acc_log[2], 32'h8);
        end
        if (hs_log.size() >= 1) check("boot_first_pc", hs_log[0], 32'h0);
    endtask

    task automatic drain();
        mem_mode = 1;
        for (int i = 0; i < 60; i++) begin
            if (live == 0 && q.size() == 0) break;
            step(0, 1, 0, 0);
        end
        check("drain_done", 32'(live == 0 && q.size() == 0), 1);
    endtask

    task automatic wait_hs(input string tag, input logic [31:0] pc);
        int n;
        n = hs_log.size();
        for (int i = 0; i < 40 && hs_log.size() == n; i++) step(1, 1, 0, 0);
        check({tag, "_seen"}, 32'(hs_log.size() > n), 1);
        if (hs_log.size() > n) check(tag, hs_log[n], pc);
    endtask

    initial begin
        int n_acc;
        int n_hs;
        do_reset();
        boot_check();

        // decode stalled: requests stop at the credit limit, nothing lost
        drain();
        n_acc = acc_log.size();
        n_hs  = hs_log.size();
        repeat (10) step(1, 0, 0, 0);
        check("stall_acc_limit", 32'(acc_log.size() - n_acc <= 2), 1);
        check("stall_no_hs", hs_log.size() - n_hs, 0);
        drain();
        check("stall_all_delivered", hs_log.size() - n_hs, acc_log.size() - n_acc);

        // redirect with two stale requests in flight
        drain();
        mem_mode = 2;
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        check("two_outstanding", q.size(), 2);
        step(1, 0, 1, 32'h103);
        mem_mode = 1;
        wait_hs("redirect_first_pc", 32'h100);

        // redirect coincident with a handshake at pc 0x8
        drain();
        step(1, 0, 1, 32'h8);
        for (int i = 0; i < 20 && !instr_valid; i++) step(1, 0, 0, 0);
        n_hs = hs_log.size();
        step(1, 1, 1, 32'h200);
        check("coincident_hs_taken", hs_log.size() - n_hs, 1);
        if (hs_log.size() > n_hs) check("coincident_hs_pc", hs_log[n_hs], 32'h8);
        wait_hs("coincident_next_pc", 32'h200);

        // PC wrap
        drain();
        acc_log.delete();
        step(1, 1, 1, 32'hFFFF_FFFC);
        repeat (6) step(1, 1, 0, 0);
        check("wrap_req_count", 32'(acc_log.size() >= 2), 1);
        if (acc_log.size() >= 2) begin
            check("wrap_addr0", acc_log[0], 32'hFFFF_FFFC);
            check("wrap_addr1", acc_log[1], 32'h0);
        end

        // random traffic
        drain();
        mem_mode = 0;
        repeat (1500)
            step($urandom_range(3, 0) != 0, $urandom_range(2, 0) != 0,
                 $urandom_range(19, 0) == 0, $urandom);

        // reset while discarding stale responses
        drain();
        mem_mode = 2;
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        step(1, 0, 1, 32'h40);
        step(1, 0, 0, 0);
        do_reset();
        boot_check();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, meaning PC and memory address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, meaning instruction width.
REQ-003 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning first fetch address.
REQ-004 SHALL have clk  input  1  sole clock; all state on rising edge.
REQ-005 SHALL have rst_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have imem_req_valid  output  1  fetch request valid.
REQ-007 SHALL have imem_req_addr  output  ADDR_WIDTH  fetch address, word aligned.
REQ-008 SHALL have imem_req_ready  input  1  memory accepts request.
REQ-009 SHALL have imem_rsp_valid  input  1  response valid, in request order, one per accepted request.
REQ-010 SHALL have imem_rsp_data  input  DATA_WIDTH  fetched instruction.
REQ-011 SHALL have instr_valid  output  1  instruction available to decode.
REQ-012 SHALL have instr  output  DATA_WIDTH  instruction; instr[6:0] drives the decoder op field.
REQ-013 SHALL have instr_pc  output  ADDR_WIDTH  address of instr.
REQ-014 SHALL have instr_ready  input  1  decode consumes instr.
REQ-015 SHALL have redirect  input  1  taken branch or jump.
REQ-016 SHALL have redirect_pc  input  ADDR_WIDTH  new fetch target.

Function
REQ-017 SHALL hold fetch PC register; request accepted (req_valid && req_ready) advances PC by 4, modulo 2^ADDR_WIDTH (0xFFFF_FFFC -> 0x0).
REQ-018 SHALL buffer {instr, pc} in a 2-entry FIFO; instr/instr_pc/instr_valid SHALL be driven from FIFO head, registered (response visible no earlier than the cycle after rsp_valid).
REQ-019 SHALL assert imem_req_valid only when outstanding requests + FIFO occupancy < 2, guaranteeing every response a FIFO slot; rsp_valid never back-pressured.
REQ-020 SHALL hold imem_req_addr stable while req_valid high and req_ready low, unless redirect.
REQ-021 SHALL pop FIFO on instr_valid && instr_ready; push and pop in same cycle SHALL keep occupancy unchanged.
REQ-022 SHALL implement FSM: FETCH (normal); DISCARD (drop responses of pre-redirect requests); FETCH->DISCARD on redirect with outstanding > 0 after this cycle's request/response; DISCARD->FETCH when drop count reaches 0.
REQ-023 On redirect: PC <= {redirect_pc[ADDR_WIDTH-1:2], 2'b00}; FIFO flushed next cycle; a request accepted in the redirect cycle SHALL be counted for discard; req_valid SHALL be low in the redirect cycle.
REQ-024 Redirect coincident with instr handshake: handshake completes (decode keeps that instr), remainder flushed.
REQ-025 In DISCARD, new requests MAY issue from redirected PC; their responses SHALL be kept only after all stale responses are dropped.
REQ-026 Response arriving in redirect cycle SHALL be dropped.

Reset
REQ-027 rst_n low SHALL immediately set PC=RESET_PC, FIFO empty, outstanding=0, drop count=0, FSM=FETCH, instr_valid=0, imem_req_valid=0, instr=0, instr_pc=0.
REQ-028 First request SHALL issue in the first rising edge cycle after rst_n deasserts; reset mid-operation SHALL abandon outstanding responses (memory reset alongside).

Configuration
REQ-029 With FETCH_PERF_CNT_EN defined, SHALL add outputs perf_fetched (32b, increments per instr handshake) and perf_stall (32b, increments each cycle instr_valid=0 outside reset), both reset to 0 and wrapping; without it, ports and counters SHALL be absent.

Structure
REQ-030 Shared package SHALL hold INSTR_BYTES=4, FETCH_DEPTH=2, fetch FSM state enum, and {instr, pc} FIFO entry struct.
REQ-031 FIFO SHALL be sub-module fetch_fifo (2-entry, push/pop/flush, full/empty).

Verification
REQ-032 Reset release, req_ready=1, 1-cycle memory: addresses 0x0,0x4,0x8; instr_valid first high 2 cycles after first request, instr_pc=0x0.
REQ-033 instr_ready=0 for 10 cycles: at most 2 requests outstanding+buffered, no response lost; on release instrs delivered in order.
REQ-034 Redirect to 0x103 with 2 outstanding: both stale responses dropped, next instr_pc=0x100.
REQ-035 Redirect same cycle as instr handshake at pc 0x8: 0x8 consumed once, next instr_pc=redirect target.
REQ-036 PC at 0xFFFF_FFFC accepted: next request address 0x0000_0000.
REQ-037 rst_n asserted mid-DISCARD: all outputs 0 immediately, FSM=FETCH, restart at RESET_PC.
